ram16x4_ctrl: RTL and testbench

- Requester-side controller that drives the 16x4 synchronous RAM (active-low chip select `csn`, read/write select `rwn`: 1 = read, 0 = write).
- Converts a valid/ready request channel from the CPU datapath/sequencer into correctly timed RAM cycles.
- Captures registered read data and returns it on a valid/ready response channel.
- Sits between the CPU control FSM and the RAM; one transaction outstanding at a time.

---
 rtl/ram16x4_ctrl_if.sv | 37 +++
 rtl/ram16x4_ctrl.sv | 159 +++++++++++++++
 tb/tb_ram16x4_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram16x4_ctrl_if.sv
// ram16x4_ctrl_if: request/response channels plus the RAM pin bundle.
// master = CPU/RAM environment side, slave = the controller.
interface ram16x4_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ram_csn;
    logic              ram_rwn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [CNT_W-1:0]  txn_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_csn, ram_rwn, ram_addr, ram_wdata, txn_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_csn, ram_rwn, ram_addr, ram_wdata, txn_count
    );
endinterface

// File: rtl/ram16x4_ctrl.sv
// ram16x4_ctrl: turns valid/ready requests into one-cycle RAM accesses.
// Define RAM16X4_CTRL_WRITE_VERIFY_EN to read back and check every write.
module ram16x4_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input logic            clk,
    input logic            rst,
    ram16x4_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ACCESS, VERIFY, CAPTURE, RESP
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              csn_q, csn_d;
    logic              rwn_q, rwn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
`endif

    // State and every output are registered; reset returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            csn_q       <= 1'b1;
            rwn_q       <= 1'b1;
            addr_q      <= '0;
            ram_wdata_q <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
            wdata_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            csn_q       <= csn_d;
            rwn_q       <= rwn_d;
            addr_q      <= addr_d;
            ram_wdata_q <= ram_wdata_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
            wdata_q     <= wdata_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and next-output logic; everything holds by default.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        csn_d       = csn_q;
        rwn_d       = rwn_q;
        addr_d      = addr_q;
        ram_wdata_d = ram_wdata_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
        wdata_d     = wdata_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    csn_d       = 1'b0;
                    rwn_d       = ~bus.req_we;
                    addr_d      = bus.req_addr;
                    ram_wdata_d = bus.req_wdata;
                    req_ready_d = 1'b0;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
                    wdata_d     = bus.req_wdata;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                csn_d = 1'b1;
                rwn_d = 1'b1;
                if (we_q) begin
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
                    // Keep the chip selected for one read-back cycle.
                    csn_d   = 1'b0;
                    state_d = VERIFY;
`else
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
`endif
                end else begin
                    state_d = CAPTURE;
                end
            end
            VERIFY: begin
                csn_d   = 1'b1;
                rwn_d   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = bus.ram_rdata;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
                if (we_q) begin
                    rsp_rdata_d = '0;
                    err_d       = (bus.ram_rdata != wdata_q);
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
                    err_d       = 1'b0;
`endif
                    if (cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_csn   = csn_q;
    assign bus.ram_rwn   = rwn_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.txn_count = cnt_q;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_ram16x4_ctrl.sv
// tb_ram16x4_ctrl: table vectors, corner sequences and random traffic
// against a word-array model of the RAM and transaction rules.
module tb_ram16x4_ctrl;
`ifdef RAM16X4_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram16x4_ctrl_if #(.ADDR_W(4), .DATA_W(4), .CNT_W(8)) bus ();

    ram16x4_ctrl #(.ADDR_W(4), .DATA_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous RAM with registered read data and an optional
    // stuck-at-zero cell at address 7.
    logic [3:0] ram_mem [16] = '{default: 4'h0};
    bit         fault_en = 1'b0;
    always @(posedge clk) begin
        if (!bus.ram_csn) begin
            if (!bus.ram_rwn)
                ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else
                bus.ram_rdata <= (fault_en && bus.ram_addr == 4'h7)
                                 ? 4'h0 : ram_mem[bus.ram_addr];
        end
    end

    logic [3:0] ref_mem [16];
    int         ref_cnt;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] model_read(input logic [3:0] a);
        return (fault_en && a == 4'h7) ? 4'h0 : ref_mem[a];
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 1);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 0);
        chk({tag, " rsp_err"},   32'(bus.rsp_err),   0);
        chk({tag, " ram_csn"},   32'(bus.ram_csn),   1);
        chk({tag, " ram_rwn"},   32'(bus.ram_rwn),   1);
        chk({tag, " ram_addr"},  32'(bus.ram_addr),  0);
        chk({tag, " ram_wdata"}, 32'(bus.ram_wdata), 0);
        chk({tag, " txn_count"}, 32'(bus.txn_count), 0);
    endtask

    // One full transaction, entered and left on a falling edge.
    task automatic do_txn(input bit we, input logic [3:0] a,
                          input logic [3:0] d, input int hold,
                          output logic [3:0] rd, output logic er);
        int         t;
        int         lat;
        int         ncs;
        bit         seen;
        int         exp_lat;
        int         exp_cs;
        logic [3:0] exp_rd;
        bit         exp_er;
        logic [3:0] readback;

        if (we) begin
            readback = (fault_en && a == 4'h7) ? 4'h0 : d;
            exp_rd   = 4'h0;
            exp_er   = VERIFY_EN && (readback != d);
            ref_mem[a] = d;
        end else begin
            exp_rd = model_read(a);
            exp_er = 1'b0;
        end
        exp_lat = we ? (VERIFY_EN ? 4 : 2) : 3;
        exp_cs  = (we && VERIFY_EN) ? 2 : 1;

        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready before accept", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 4'($urandom);
        bus.req_wdata = 4'($urandom);

        lat  = 1;
        ncs  = 0;
        seen = 1'b0;
        while (!bus.rsp_valid && lat < 12) begin
            if (!bus.ram_csn) begin
                if (!seen) begin
                    chk("ram_rwn", 32'(bus.ram_rwn), 32'(!we));
                    chk("ram_addr", 32'(bus.ram_addr), 32'(a));
                    if (we)
                        chk("ram_wdata", 32'(bus.ram_wdata), 32'(d));
                    seen = 1'b1;
                end
                ncs++;
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp latency", 32'(lat), 32'(exp_lat));
        chk("csn low cycles", 32'(ncs), 32'(exp_cs));
        chk("csn at rsp", 32'(bus.ram_csn), 1);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_er));
        rd = bus.rsp_rdata;
        er = bus.rsp_err;

        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("hold rsp_valid", 32'(bus.rsp_valid), 1);
            chk("hold rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
            chk("hold req_ready", 32'(bus.req_ready), 0);
            chk("hold csn", 32'(bus.ram_csn), 1);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (ref_cnt < 255)
            ref_cnt++;
        chk("post rsp_valid", 32'(bus.rsp_valid), 0);
        chk("post req_ready", 32'(bus.req_ready), 1);
        chk("txn_count", 32'(bus.txn_count), 32'(ref_cnt));
    endtask

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [3:0] wdata;
        int         hold;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] rd;
    logic       er;

    initial begin
        tbl[0] = '{1'b1, 4'h3, 4'hA, 0, 4'h0};
        tbl[1] = '{1'b0, 4'h3, 4'h0, 0, 4'hA};
        tbl[2] = '{1'b1, 4'h0, 4'h5, 1, 4'h0};
        tbl[3] = '{1'b1, 4'hF, 4'hC, 0, 4'h0};
        tbl[4] = '{1'b0, 4'h0, 4'h0, 2, 4'h5};
        tbl[5] = '{1'b0, 4'hF, 4'h0, 0, 4'hC};
        tbl[6] = '{1'b1, 4'h3, 4'h1, 0, 4'h0};
        tbl[7] = '{1'b0, 4'h3, 4'h0, 6, 4'h1};

        n_chk   = 0;
        n_fail  = 0;
        ref_cnt = 0;
        for (int i = 0; i < 16; i++)
            ref_mem[i] = 4'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 4'h0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_vals("idle");

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, er);
            chk($sformatf("table[%0d] rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
        end

        // Reset while a write to 0x5 is in its RAM access cycle.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'h5;
        bus.req_wdata = 4'h6;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort csn in access", 32'(bus.ram_csn), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("abort");
        ref_mem[5] = 4'h6;
        ref_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no rsp", 32'(bus.rsp_valid), 0);
            chk("abort csn idle", 32'(bus.ram_csn), 1);
        end
        do_txn(1'b0, 4'h5, 4'h0, 0, rd, er);
        chk("abort write stands", 32'(rd), 32'h6);

        for (int i = 0; i < 40; i++)
            do_txn(1'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), rd, er);

        if (VERIFY_EN) begin
            fault_en = 1'b1;
            do_txn(1'b1, 4'h7, 4'h9, 0, rd, er);
            chk("verify fault err", 32'(er), 1);
            chk("verify fault rdata", 32'(rd), 0);
            do_txn(1'b1, 4'h2, 4'h3, 0, rd, er);
            chk("verify healthy err", 32'(er), 0);
            fault_en = 1'b0;
        end

        // Enough transactions to pin the counter at its ceiling.
        for (int i = 0; i < 260; i++)
            do_txn(1'b1, 4'($urandom), 4'($urandom), 0, rd, er);
        chk("txn_count saturated", 32'(bus.txn_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
